pa_ram_loader: RTL and testbench

//  Write-side sequencer for the 16-bank cross-coded weight RAM. Accepts a valid/ready stream
//  of 32-bit words from the DMA/host side and issues one registered RAM write per word.

---
 rtl/pa_ram_loader.sv | 140 ++++++++++++++
 tb/tb_pa_ram_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pa_ram_loader.sv
// Write-side sequencer for the banked weight RAM: turns a valid/ready word stream
// into registered RAM writes, filling bank 0 words 0..wpb-1, then bank 1, and so on.
module pa_ram_loader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int BANKS      = 16,
    parameter int BANK_DEPTH = 512
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [31:0]             rhs_cols,
    input  logic                    s_valid,
    input  logic [4*DATA_WIDTH-1:0] s_data,
    output logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [4*DATA_WIDTH-1:0] ram_data,
    output logic                    ram_we,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int WORD_W = 9;
    localparam int BANK_W = ADDR_WIDTH - WORD_W;
    localparam int DW     = 4 * DATA_WIDTH;

    localparam logic [WORD_W:0]   WORD_ONE  = 1;
    localparam logic [BANK_W-1:0] BANK_ONE  = 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(BANKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q,    state_d;
    // One bit wider than the word index so wpb=512 compares without wrapping.
    logic [WORD_W:0]       wpb_q,      wpb_d;
    logic [WORD_W:0]       word_q,     word_d;
    logic [BANK_W-1:0]     bank_q,     bank_d;
    logic                  ram_we_q,   ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0]         ram_data_q, ram_data_d;
    logic                  err_q,      err_d;
    logic                  cols_ok;

    assign cols_ok = (rhs_cols != 32'd0) && (rhs_cols <= 32'(BANK_DEPTH));

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case
        // leaves a value unassigned and no latch is inferred.
        state_d    = state_q;
        wpb_d      = wpb_q;
        word_d     = word_q;
        bank_d     = bank_q;
        ram_we_d   = 1'b0;
        ram_addr_d = '0;
        ram_data_d = '0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cols_ok) begin
                        state_d = S_LOAD;
                        wpb_d   = rhs_cols[WORD_W:0];
                        word_d  = '0;
                        bank_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // Abort wins over a same-cycle handshake; that word is dropped.
                if (abort) begin
                    state_d = S_IDLE;
                    word_d  = '0;
                    bank_d  = '0;
                end else if (s_valid) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = {bank_q, word_q[WORD_W-1:0]};
                    ram_data_d = s_data;
                    if (word_q == wpb_q - WORD_ONE) begin
                        word_d = '0;
                        bank_d = bank_q + BANK_ONE;
                        if (bank_q == LAST_BANK) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        word_d = word_q + WORD_ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                word_d  = '0;
                bank_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values computed above.
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wpb_q      <= '0;
            word_q     <= '0;
            bank_q     <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wpb_q      <= wpb_d;
            word_q     <= word_d;
            bank_q     <= bank_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            err_q      <= err_d;
        end
    end

    assign s_ready  = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_data = ram_data_q;

endmodule

// File: tb/tb_pa_ram_loader.sv
// Randomised bench for pa_ram_loader: a load-level model predicts every output
// each cycle from the accepted-word index n (bank = n / wpb, word = n % wpb).
module tb_pa_ram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] rhs_cols = '0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic [12:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic        err;

    pa_ram_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rhs_cols(rhs_cols),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_we(ram_we), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        we;
        logic [12:0] addr;
        logic [31:0] data;
        logic        busy;
        logic        done;
        logic        err;
    } outs_t;

    outs_t obs, exp_o;
    int    vectors = 0;
    int    miscompares = 0;
    int    we_count = 0;

    // Model: phase 0 = idle, 1 = accepting words, 2 = final write on the bus.
    int m_phase = 0;
    int m_n = 0;
    int m_wpb = 1;

    task automatic sample();
        obs = {s_ready, ram_we, ram_addr, ram_data, busy, done, err};
        if (ram_we) we_count++;
    endtask

    task automatic cycle(input logic v, input logic [31:0] d, input logic st,
                         input logic ab, input logic [31:0] cols);
        bit hs, last;
        s_valid = v; s_data = d; start = st; abort = ab; rhs_cols = cols;
        hs   = (m_phase == 1) && v && !ab;
        last = hs && (m_n == 16 * m_wpb - 1);
        exp_o = '0;
        exp_o.we = hs;
        if (hs) begin
            exp_o.addr = 13'((m_n / m_wpb) * 512 + (m_n % m_wpb));
            exp_o.data = d;
        end
        exp_o.done = last;
        exp_o.err  = (m_phase == 0) && st && !ab && (cols == 0 || cols > 512);
        case (m_phase)
            0: if (st && !ab && cols >= 1 && cols <= 512) begin
                   m_phase = 1; m_n = 0; m_wpb = int'(cols);
               end
            1: if (ab) m_phase = 0;
               else if (last) m_phase = 2;
               else if (hs) m_n++;
            default: m_phase = 0;
        endcase
        exp_o.busy  = (m_phase != 0);
        exp_o.ready = (m_phase == 1);
        @(posedge clk); #1;
        sample();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b1; start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            sample();
            if (obs !== outs_t'('0)) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%h exp=0", i, obs);
            end
            vectors++;
        end
        m_phase = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        we_count = 0;
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd2);
        for (int i = 0; i < 33; i++) begin
            cycle(i < 32, 32'(i), 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL b2b i=%0d got=%h exp=%h", i, obs, exp_o);
            end
            vectors++;
            if (i == 31) begin
                if (!(done && ram_we && ram_addr == 13'h1E01 && ram_data == 32'd31)) begin
                    miscompares++;
                    $display("FAIL b2b_done got done=%b addr=%h exp done=1 addr=1e01", done, ram_addr);
                end
                vectors++;
            end
        end
        if (we_count != 32) begin
            miscompares++;
            $display("FAIL b2b_count got=%0d exp=32", we_count);
        end
        vectors++;
    endtask

    task automatic test_stalls();
        int cyc = 0;
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd3);
        while (m_phase == 1 && cyc < 1000) begin
            cycle($urandom_range(0, 2) == 0, $urandom, 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, obs, exp_o);
            end
            vectors++;
            cyc++;
        end
        if (m_phase != 2) begin
            miscompares++;
            $display("FAIL stall_timeout got phase=%0d exp=2", m_phase);
        end
        vectors++;
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic test_full_depth();
        int cyc = 0;
        bit saw_last = 0;
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd512);
        while (m_phase == 1 && cyc < 9000) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL full cyc=%0d got=%h exp=%h", cyc, obs, exp_o);
            end
            vectors++;
            if (m_phase == 2) saw_last = (done && ram_addr == 13'h1FFF);
            cyc++;
        end
        if (!saw_last) begin
            miscompares++;
            $display("FAIL full_last got done=%b addr=%h exp done=1 addr=1fff", done, ram_addr);
        end
        vectors++;
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL full_busy_drop got=%b exp=0", busy);
        end
        vectors++;
    endtask

    task automatic test_bad_cols();
        logic [31:0] bad [3] = '{32'd0, 32'd513, 32'hFFFF_FFFF};
        we_count = 0;
        foreach (bad[k]) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0, bad[k]);
            if (obs !== exp_o || err !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_cols cols=%0d got=%h exp=%h", bad[k], obs, exp_o);
            end
            vectors++;
            cycle(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL bad_cols_after got=%h exp=%h", obs, exp_o);
            end
            vectors++;
        end
        if (we_count != 0) begin
            miscompares++;
            $display("FAIL bad_cols_we got=%0d exp=0", we_count);
        end
        vectors++;
    endtask

    task automatic test_abort();
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'd4);
        for (int i = 0; i < 5; i++) cycle(i > 0, $urandom, i == 0, 1'b0, 32'd4);
        cycle(1'b1, $urandom, 1'b1, 1'b0, 32'd1);
        if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL start_while_busy got=%h exp=%h", obs, exp_o);
        end
        vectors++;
        cycle(1'b1, $urandom, 1'b0, 1'b1, 32'd0);
        if (obs !== exp_o || busy !== 1'b0 || done !== 1'b0 || ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL abort got=%h exp=%h", obs, exp_o);
        end
        vectors++;
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd1);
        for (int i = 0; i < 17; i++) begin
            cycle(i < 16, $urandom, 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL wpb1 i=%0d got=%h exp=%h", i, obs, exp_o);
            end
            vectors++;
            if (i == 0 && !(ram_we && ram_addr == 13'h0000)) begin
                miscompares++;
                $display("FAIL wpb1_first got we=%b addr=%h exp we=1 addr=0000", ram_we, ram_addr);
            end
            if (i == 0) vectors++;
        end
    endtask

    task automatic test_mid_reset();
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd2);
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
        we_count = 0;
        test_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, $urandom, 1'b0, 1'b0, 32'd0);
            if (obs !== exp_o) begin
                miscompares++;
                $display("FAIL post_reset i=%0d got=%h exp=%h", i, obs, exp_o);
            end
            vectors++;
        end
        if (we_count != 0) begin
            miscompares++;
            $display("FAIL post_reset_we got=%0d exp=0", we_count);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stalls();
        test_full_depth();
        test_bad_cols();
        test_abort();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
